// File: rtl/perceptron_pkg.sv
// Shared types and helpers for the perceptron trainer: FSM state encoding,
// width derivation for the MAC accumulator and a saturating clamp.
package perceptron_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_MAC       = 3'd2,
    ST_DECIDE    = 3'd3,
    ST_UPDATE    = 3'd4,
    ST_EPOCH_END = 3'd5,
    ST_DONE      = 3'd6
  } state_e;

  // Ceiling log2 for elaboration-time width math; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Accumulator width: product width plus headroom for N_INPUTS+1 terms
  // (the bias counts as one extra term), so the sum can never overflow.
  function automatic int acc_width(input int data_w, input int weight_w, input int n_inputs);
    return data_w + weight_w + clog2(n_inputs + 1);
  endfunction

  // Clamp a wide signed sum into the signed range of 'width' bits.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] value, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/perceptron_mac.sv
// Sequential single-multiplier dot product: acc = bias + sum(w_i * x_i),
// one channel per cycle. done_o flags the cycle in which the final channel
// is being added, so acc_o is complete on the following cycle.
module perceptron_mac
  import perceptron_pkg::*;
#(
  parameter int N_INPUTS = 2,
  parameter int DATA_W   = 7,
  parameter int WEIGHT_W = 14,
  parameter int ACC_W    = acc_width(DATA_W, WEIGHT_W, N_INPUTS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic [WEIGHT_W-1:0]          bias_i,
  input  logic [N_INPUTS*WEIGHT_W-1:0] w_i,
  input  logic [N_INPUTS*DATA_W-1:0]   x_i,
  output logic [ACC_W-1:0]             acc_o,
  output logic                         done_o
);

  localparam int IDX_W = clog2(N_INPUTS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);
  localparam int PROD_W = WEIGHT_W + DATA_W;

  logic [IDX_W-1:0]         idx_q;
  logic [ACC_W-1:0]         acc_q;
  logic                     run_q;
  logic signed [PROD_W-1:0] prod_s;

  // Multiply the currently selected channel at full product width.
  always_comb begin
    prod_s = $signed(w_i[idx_q*WEIGHT_W +: WEIGHT_W]) * $signed(x_i[idx_q*DATA_W +: DATA_W]);
  end

  // Seed with the sign-extended bias, then add one product per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      acc_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      idx_q <= '0;
      acc_q <= {{(ACC_W-WEIGHT_W){bias_i[WEIGHT_W-1]}}, bias_i};
      run_q <= 1'b1;
    end else if (run_q) begin
      acc_q <= acc_q + {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
      if (idx_q == LAST_IDX) begin
        idx_q <= '0;
        run_q <= 1'b0;
      end else begin
        idx_q <= idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign acc_o  = acc_q;
  assign done_o = run_q && (idx_q == LAST_IDX);

endmodule

// File: rtl/perceptron_trainer.sv
// Single-layer perceptron trainer (Fausett rule). Samples arrive over a
// valid/ready handshake; training ends on the first error-free epoch or at
// the epoch cap. Weight storage and the control FSM live here.
module perceptron_trainer
  import perceptron_pkg::*;
#(
  parameter int N_INPUTS    = 2,
  parameter int DATA_W      = 7,
  parameter int WEIGHT_W    = 14,
  parameter int ALPHA_SHIFT = 0,
  parameter int MAX_EPOCHS  = 255,
  parameter int CNT_W       = 32,
  localparam int ACC_W      = acc_width(DATA_W, WEIGHT_W, N_INPUTS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [CNT_W-1:0]             num_samples,
  input  logic [ACC_W-1:0]             theta,
  input  logic [N_INPUTS*DATA_W-1:0]   x_bus,
  input  logic signed [1:0]            t_bus,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [N_INPUTS*WEIGHT_W-1:0] weights,
  output logic [WEIGHT_W-1:0]          bias,
  output logic                         busy,
  output logic                         update_pulse,
  output logic                         epoch_done,
  output logic                         done,
  output logic                         converged,
  output logic [CNT_W-1:0]             epoch_count
);

  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_EPOCHS);
  localparam logic [DATA_W-1:0] UNIT_X  = DATA_W'(1);

  state_e                       state_q, state_d;
  logic [N_INPUTS*WEIGHT_W-1:0] w_q, w_d, w_upd_s;
  logic [WEIGHT_W-1:0]          b_q, b_d;
  logic [N_INPUTS*DATA_W-1:0]   x_q, x_d;
  logic                         t_pos_q, t_pos_d;
  logic [CNT_W-1:0]             num_q, num_d;
  logic [ACC_W-1:0]             theta_q, theta_d;
  logic [CNT_W-1:0]             idx_q, idx_d;
  logic [CNT_W-1:0]             epoch_q, epoch_d;
  logic                         err_q, err_d;
  logic                         conv_q, conv_d;
  logic                         mac_start_s, mac_done_s;
  logic [ACC_W-1:0]             mac_acc_s;
  logic signed [ACC_W:0]        net_s, th_s;
  logic                         mismatch_s, last_s;

  // w + ((t * x) <<< ALPHA_SHIFT), saturated to the weight range.
  function automatic logic [WEIGHT_W-1:0] step_weight(input logic [WEIGHT_W-1:0] w,
                                                      input logic [DATA_W-1:0] x,
                                                      input logic t_pos);
    logic signed [63:0] w_ext;
    logic signed [63:0] step;
    logic signed [63:0] sum;
    w_ext = {{(64-WEIGHT_W){w[WEIGHT_W-1]}}, w};
    step  = {{(64-DATA_W){x[DATA_W-1]}}, x} <<< ALPHA_SHIFT;
    if (t_pos) begin
      sum = w_ext + step;
    end else begin
      sum = w_ext - step;
    end
    sum = sat_add(sum, WEIGHT_W);
    return sum[WEIGHT_W-1:0];
  endfunction

  perceptron_mac #(
    .N_INPUTS (N_INPUTS),
    .DATA_W   (DATA_W),
    .WEIGHT_W (WEIGHT_W),
    .ACC_W    (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (mac_start_s),
    .bias_i  (b_q),
    .w_i     (w_q),
    .x_i     (x_q),
    .acc_o   (mac_acc_s),
    .done_o  (mac_done_s)
  );

  // Candidate weights for an update step, one saturating adder per channel.
  always_comb begin
    w_upd_s = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      w_upd_s[i*WEIGHT_W +: WEIGHT_W] = step_weight(w_q[i*WEIGHT_W +: WEIGHT_W],
                                                    x_q[i*DATA_W +: DATA_W], t_pos_q);
    end
  end

  // Classification against the latched threshold; one extra bit keeps -theta exact.
  always_comb begin
    net_s      = {mac_acc_s[ACC_W-1], mac_acc_s};
    th_s       = {1'b0, theta_q};
    mismatch_s = t_pos_q ? !(net_s > th_s) : !(net_s < -th_s);
    last_s     = (idx_q == (num_q - CNT_ONE));
  end

  // Next-state and datapath control for the training FSM.
  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    b_d         = b_q;
    x_d         = x_q;
    t_pos_d     = t_pos_q;
    num_d       = num_q;
    theta_d     = theta_q;
    idx_d       = idx_q;
    epoch_d     = epoch_q;
    err_d       = err_q;
    conv_d      = conv_q;
    mac_start_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_d     = '0;
          b_d     = '0;
          epoch_d = '0;
          err_d   = 1'b0;
          conv_d  = 1'b0;
          idx_d   = '0;
          num_d   = num_samples;
          theta_d = theta;
          if (num_samples == '0) begin
            conv_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_FETCH: begin
        if (s_valid) begin
          x_d         = x_bus;
          t_pos_d     = (t_bus > 2'sd0);
          mac_start_s = 1'b1;
          state_d     = ST_MAC;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_MAC: begin
        if (mac_done_s) begin
          state_d = ST_DECIDE;
        end else begin
          state_d = ST_MAC;
        end
      end
      ST_DECIDE: begin
        if (mismatch_s) begin
          err_d   = 1'b1;
          state_d = ST_UPDATE;
        end else if (last_s) begin
          state_d = ST_EPOCH_END;
        end else begin
          idx_d   = idx_q + CNT_ONE;
          state_d = ST_FETCH;
        end
      end
      ST_UPDATE: begin
        w_d = w_upd_s;
        b_d = step_weight(b_q, UNIT_X, t_pos_q);
        if (last_s) begin
          state_d = ST_EPOCH_END;
        end else begin
          idx_d   = idx_q + CNT_ONE;
          state_d = ST_FETCH;
        end
      end
      ST_EPOCH_END: begin
        epoch_d = epoch_q + CNT_ONE;
        if (!err_q) begin
          conv_d  = 1'b1;
          state_d = ST_DONE;
        end else if ((epoch_q + CNT_ONE) == CNT_MAX) begin
          conv_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          err_d   = 1'b0;
          idx_d   = '0;
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      b_q     <= '0;
      x_q     <= '0;
      t_pos_q <= 1'b0;
      num_q   <= '0;
      theta_q <= '0;
      idx_q   <= '0;
      epoch_q <= '0;
      err_q   <= 1'b0;
      conv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      b_q     <= b_d;
      x_q     <= x_d;
      t_pos_q <= t_pos_d;
      num_q   <= num_d;
      theta_q <= theta_d;
      idx_q   <= idx_d;
      epoch_q <= epoch_d;
      err_q   <= err_d;
      conv_q  <= conv_d;
    end
  end

  // Status outputs are pure decodes of the state register.
  assign s_ready      = (state_q == ST_FETCH);
  assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign update_pulse = (state_q == ST_UPDATE);
  assign epoch_done   = (state_q == ST_EPOCH_END);
  assign done         = (state_q == ST_DONE);
  assign converged    = conv_q;
  assign weights      = w_q;
  assign bias         = b_q;
  assign epoch_count  = epoch_q;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed bench for perceptron_trainer: three instances (AND/default,
// XOR with a 5-epoch cap, and a narrow-weight saturation build).
module tb_perceptron_trainer;

  typedef struct {
    int x0;
    int x1;
    int t;
  } sample_t;

  typedef struct {
    int dut;
    int set;
    bit stress;
    int w0;
    int w1;
    int b;
    int ep;
    int conv;
    int upd1;
  } case_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // AND / default instance
  logic start_a, v_a, r_a, busy_a, upd_a, ed_a, done_a, conv_a;
  logic [31:0] num_a, ep_a;
  logic [22:0] theta_a;
  logic [13:0] x_a, b_a;
  logic [1:0]  t_a;
  logic [27:0] w_a;
  // XOR instance, MAX_EPOCHS = 5
  logic start_x, v_x, r_x, busy_x, upd_x, ed_x, done_x, conv_x;
  logic [31:0] num_x, ep_x;
  logic [22:0] theta_x;
  logic [13:0] x_x, b_x;
  logic [1:0]  t_x;
  logic [27:0] w_x;
  // Saturation instance, N_INPUTS = 1, WEIGHT_W = 4
  logic start_s, v_s, r_s, busy_s, upd_s, ed_s, done_s, conv_s;
  logic [31:0] num_s, ep_s;
  logic [11:0] theta_s;
  logic [6:0]  x_s;
  logic [1:0]  t_s;
  logic [3:0]  w_s, b_s;

  perceptron_trainer dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .num_samples(num_a), .theta(theta_a),
    .x_bus(x_a), .t_bus(t_a), .s_valid(v_a), .s_ready(r_a), .weights(w_a), .bias(b_a),
    .busy(busy_a), .update_pulse(upd_a), .epoch_done(ed_a), .done(done_a),
    .converged(conv_a), .epoch_count(ep_a));

  perceptron_trainer #(.MAX_EPOCHS(5)) dut_x (
    .clk(clk), .rst_n(rst_n), .start(start_x), .num_samples(num_x), .theta(theta_x),
    .x_bus(x_x), .t_bus(t_x), .s_valid(v_x), .s_ready(r_x), .weights(w_x), .bias(b_x),
    .busy(busy_x), .update_pulse(upd_x), .epoch_done(ed_x), .done(done_x),
    .converged(conv_x), .epoch_count(ep_x));

  perceptron_trainer #(.N_INPUTS(1), .DATA_W(7), .WEIGHT_W(4), .MAX_EPOCHS(10)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .num_samples(num_s), .theta(theta_s),
    .x_bus(x_s), .t_bus(t_s), .s_valid(v_s), .s_ready(r_s), .weights(w_s), .bias(b_s),
    .busy(busy_s), .update_pulse(upd_s), .epoch_done(ed_s), .done(done_s),
    .converged(conv_s), .epoch_count(ep_s));

  int n_pass = 0;
  int n_total = 0;
  int upd_cnt [3] = '{0, 0, 0};
  sample_t samples [3][4];
  case_t cases [4];

  // Running count of update pulses per instance.
  always @(posedge clk) begin
    if (upd_a) upd_cnt[0] <= upd_cnt[0] + 1;
    if (upd_x) upd_cnt[1] <= upd_cnt[1] + 1;
    if (upd_s) upd_cnt[2] <= upd_cnt[2] + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int get_w(input int s, input int i);
    case (s)
      0: return int'($signed(w_a[i*14 +: 14]));
      1: return int'($signed(w_x[i*14 +: 14]));
      default: return int'($signed(w_s));
    endcase
  endfunction

  function automatic int get_b(input int s);
    case (s)
      0: return int'($signed(b_a));
      1: return int'($signed(b_x));
      default: return int'($signed(b_s));
    endcase
  endfunction

  function automatic int get_ep(input int s);
    case (s)
      0: return int'(ep_a);
      1: return int'(ep_x);
      default: return int'(ep_s);
    endcase
  endfunction

  function automatic logic rdy(input int s);
    case (s)
      0: return r_a;
      1: return r_x;
      default: return r_s;
    endcase
  endfunction

  function automatic logic dn(input int s);
    case (s)
      0: return done_a;
      1: return done_x;
      default: return done_s;
    endcase
  endfunction

  function automatic logic cv(input int s);
    case (s)
      0: return conv_a;
      1: return conv_x;
      default: return conv_s;
    endcase
  endfunction

  function automatic logic bsy(input int s);
    case (s)
      0: return busy_a;
      1: return busy_x;
      default: return busy_s;
    endcase
  endfunction

  task automatic drive(input int s, input sample_t sm, input logic v);
    logic [6:0] x0, x1;
    logic [1:0] t;
    x0 = 7'(sm.x0);
    x1 = 7'(sm.x1);
    t  = 2'(sm.t);
    case (s)
      0: begin x_a = {x1, x0}; t_a = t; v_a = v; end
      1: begin x_x = {x1, x0}; t_x = t; v_x = v; end
      default: begin x_s = x0; t_s = t; v_s = v; end
    endcase
  endtask

  task automatic pulse_start(input int s, input int num, input int th);
    case (s)
      0: begin start_a = 1'b1; num_a = num; theta_a = 23'(th); end
      1: begin start_x = 1'b1; num_x = num; theta_x = 23'(th); end
      default: begin start_s = 1'b1; num_s = num; theta_s = 12'(th); end
    endcase
    @(posedge clk); #1;
    start_a = 1'b0; start_x = 1'b0; start_s = 1'b0;
  endtask

  task automatic feed(input int s, input sample_t sm);
    bit ok;
    ok = 1'b0;
    drive(s, sm, 1'b1);
    for (int c = 0; c < 64 && !ok; c++) begin
      if (rdy(s)) ok = 1'b1;
      @(posedge clk); #1;
    end
    drive(s, sm, 1'b0);
    if (!ok) check("feed_timeout", 0, 1);
  endtask

  task automatic wait_boundary(input int s);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 64 && !ok; c++) begin
      if (rdy(s) || dn(s)) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) check("epoch_timeout", 0, 1);
  endtask

  task automatic train(input int s, input int set, input int th, input bit stress, output int upd1);
    int c0;
    int e;
    pulse_start(s, 4, th);
    c0 = upd_cnt[s];
    upd1 = 0;
    if (stress) begin
      for (int c = 0; c < 10; c++) begin
        check("bp_ready", int'(rdy(s)), 1);
        @(posedge clk); #1;
      end
      check("bp_epoch", get_ep(s), 0);
      check("bp_upd", upd_cnt[s] - c0, 0);
    end
    e = 0;
    while (!dn(s) && e < 300) begin
      for (int k = 0; k < 4; k++) begin
        if (stress) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        feed(s, samples[set][k]);
        if (stress && e == 0 && k == 0) begin
          pulse_start(s, 0, 0);
          check("mid_start_busy", int'(bsy(s)), 1);
          check("mid_start_done", int'(dn(s)), 0);
        end
      end
      wait_boundary(s);
      if (e == 0) upd1 = upd_cnt[s] - c0;
      e++;
    end
  endtask

  initial begin
    int xs0 [4] = '{1, 1, -1, -1};
    int xs1 [4] = '{1, -1, 1, -1};
    int t_and [4] = '{1, -1, -1, -1};
    int t_xor [4] = '{-1, 1, 1, -1};
    int t_and0 [4] = '{1, 0, 0, 0};
    int upd1, wm, bm;
    sample_t sat_smp;

    for (int k = 0; k < 4; k++) begin
      samples[0][k] = '{xs0[k], xs1[k], t_and[k]};
      samples[1][k] = '{xs0[k], xs1[k], t_xor[k]};
      samples[2][k] = '{xs0[k], xs1[k], t_and0[k]};
    end
    cases[0] = '{0, 0, 1'b0, 1, 1, -1, 2, 1, 3};
    cases[1] = '{1, 1, 1'b0, 0, 0, 0, 5, 0, 4};
    cases[2] = '{0, 2, 1'b0, 1, 1, -1, 2, 1, 3};
    cases[3] = '{0, 0, 1'b1, 1, 1, -1, 2, 1, 3};
    sat_smp = '{7, 0, 1};

    start_a = 0; num_a = 0; theta_a = 0; x_a = 0; t_a = 0; v_a = 0;
    start_x = 0; num_x = 0; theta_x = 0; x_x = 0; t_x = 0; v_x = 0;
    start_s = 0; num_s = 0; theta_s = 0; x_s = 0; t_s = 0; v_s = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", int'(r_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_conv", int'(conv_a), 0);
    check("rst_w0", get_w(0, 0), 0);
    check("rst_b", get_b(0), 0);
    check("rst_ep", get_ep(0), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven training runs.
    for (int i = 0; i < 4; i++) begin
      train(cases[i].dut, cases[i].set, 0, cases[i].stress, upd1);
      check($sformatf("c%0d_done", i), int'(dn(cases[i].dut)), 1);
      check($sformatf("c%0d_conv", i), int'(cv(cases[i].dut)), cases[i].conv);
      check($sformatf("c%0d_epochs", i), get_ep(cases[i].dut), cases[i].ep);
      check($sformatf("c%0d_w0", i), get_w(cases[i].dut, 0), cases[i].w0);
      check($sformatf("c%0d_w1", i), get_w(cases[i].dut, 1), cases[i].w1);
      check($sformatf("c%0d_bias", i), get_b(cases[i].dut), cases[i].b);
      check($sformatf("c%0d_upd_ep1", i), upd1, cases[i].upd1);
    end

    // Empty data set converges immediately with all state cleared.
    pulse_start(0, 0, 0);
    check("zero_done", int'(done_a), 1);
    check("zero_conv", int'(conv_a), 1);
    check("zero_ep", get_ep(0), 0);
    check("zero_bias", get_b(0), 0);
    check("zero_w1", get_w(0, 1), 0);

    // Saturation: w0 clamps at 7 after one step, bias climbs 1/epoch to 7.
    pulse_start(2, 1, 100);
    wm = 0;
    bm = 0;
    for (int e = 0; e < 10; e++) begin
      feed(2, sat_smp);
      wait_boundary(2);
      wm = (wm + 7 > 7) ? 7 : wm + 7;
      bm = (bm + 1 > 7) ? 7 : bm + 1;
      check($sformatf("sat_w0_e%0d", e), get_w(2, 0), wm);
      check($sformatf("sat_b_e%0d", e), get_b(2), bm);
      check($sformatf("sat_ep_e%0d", e), get_ep(2), e + 1);
    end
    check("sat_done", int'(done_s), 1);
    check("sat_conv", int'(conv_s), 0);

    // Asynchronous reset during MAC of the second sample in epoch 1.
    pulse_start(0, 4, 0);
    feed(0, samples[0][0]);
    feed(0, samples[0][1]);
    check("pre_rst_w0", get_w(0, 0), 1);
    check("pre_rst_busy", int'(busy_a), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_w0", get_w(0, 0), 0);
    check("arst_b", get_b(0), 0);
    check("arst_busy", int'(busy_a), 0);
    check("arst_ready", int'(r_a), 0);
    check("arst_done", int'(done_a), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    train(0, 0, 0, 1'b0, upd1);
    check("post_rst_conv", int'(conv_a), 1);
    check("post_rst_ep", get_ep(0), 2);
    check("post_rst_w0", get_w(0, 0), 1);
    check("post_rst_w1", get_w(0, 1), 1);
    check("post_rst_b", get_b(0), -1);
    check("post_rst_upd1", upd1, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/perceptron_trainer.md
Name: perceptron_trainer

Overview:
- Parametrised successor to the two-input neuron trainer: trains a single-layer perceptron with N_INPUTS signed inputs, a bias and a bipolar target, using the Fausett rule (threshold theta, integer learning rate as a left shift).
- Samples stream in over a valid/ready handshake. The testbench or host re-presents the whole data set every epoch.
- Training stops on the first error-free epoch or at an epoch cap. The block reports weights, bias, convergence and epoch count.

Parameters:
- N_INPUTS, 2, number of input channels (1..16).
- DATA_W, 7, signed input sample width.
- WEIGHT_W, 14, signed weight/bias width.
- ALPHA_SHIFT, 0, learning rate = 2^ALPHA_SHIFT.
- MAX_EPOCHS, 255, epoch cap (>=1).
- CNT_W, 32, width of sample-count and epoch counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin training; sampled only in IDLE/DONE.
- num_samples  in  CNT_W  samples per epoch; latched on start.
- theta  in  ACC_W  unsigned threshold; latched on start.
- x_bus  in  N_INPUTS*DATA_W  packed signed inputs; channel i at [i*DATA_W +: DATA_W].
- t_bus  in  2  signed target, +1 or -1.
- s_valid  in  1  sample present.
- s_ready  out  1  block can accept a sample.
- weights  out  N_INPUTS*WEIGHT_W  packed signed weights.
- bias  out  WEIGHT_W  signed bias.
- busy  out  1  training in progress.
- update_pulse  out  1  one-cycle pulse on every weight update.
- epoch_done  out  1  one-cycle pulse at the end of each epoch.
- done  out  1  level; high in DONE.
- converged  out  1  valid while done is high.
- epoch_count  out  CNT_W  completed epochs.

Behaviour:
- ACC_W = DATA_W + WEIGHT_W + clog2(N_INPUTS+1).
- Reset: all outputs are 0; weights and bias are 0; state is IDLE.
- States: IDLE, FETCH, MAC, DECIDE, UPDATE, EPOCH_END, DONE.
- IDLE or DONE with start=1:
  - Clear weights, bias, epoch_count, done, converged and the error flag.
  - Latch num_samples and theta.
  - If num_samples==0, go to DONE with converged=1 and epoch_count=0.
  - Otherwise go to FETCH.
- start asserted in any other state is ignored.
- FETCH:
  - s_ready=1.
  - On s_valid&&s_ready, register x_bus and t_bus and go to MAC.
  - With s_valid low, hold with no state change.
  - s_ready is 0 in every other state.
- MAC:
  - Takes N_INPUTS cycles, one channel per cycle.
  - The accumulator is initialised to the sign-extended bias and accumulates w_i*x_i at full width; no overflow is possible at ACC_W.
- DECIDE (1 cycle):
  - y = +1 if net > theta, -1 if net < -theta, else 0.
  - If y != t, go to UPDATE and set the error flag.
  - Otherwise go to FETCH, or to EPOCH_END if this was the last sample.
- UPDATE (1 cycle):
  - w_i += (t*x_i) <<< ALPHA_SHIFT.
  - bias += t <<< ALPHA_SHIFT.
  - Each result saturates to [-2^(WEIGHT_W-1), 2^(WEIGHT_W-1)-1].
  - update_pulse=1.
  - Then go to FETCH, or to EPOCH_END if this was the last sample.
- Per-sample latency from acceptance to next s_ready: N_INPUTS+1 cycles with no error, N_INPUTS+2 with an error.
- EPOCH_END (1 cycle):
  - epoch_count++ and epoch_done=1.
  - If the error flag is 0: DONE with converged=1.
  - Else if epoch_count+1 == MAX_EPOCHS: DONE with converged=0.
  - Else: clear the error flag, reset the sample index and go to FETCH.
- DONE: done=1 and busy=0. weights and bias hold until the next start.
- busy=1 in FETCH through EPOCH_END.
- Reset mid-operation returns to IDLE immediately and clears all state. An in-flight sample is discarded.
- t_bus values 0 or -2 are illegal; the design treats any non-positive value as -1.

Decomposition:
- Package perceptron_pkg holds:
  - The state enum.
  - Functions clog2 and sat_add(value, width).
  - The ACC_W derivation.
- One sub-module, perceptron_mac: sequential single-multiplier accumulator with its own start/done. Weight storage and the FSM stay in the top level.

Test Plan:
- Bipolar AND (N_INPUTS=2, theta=0, ALPHA_SHIFT=0), samples (1,1,+1) (1,-1,-1) (-1,1,-1) (-1,-1,-1):
  - 3 update_pulses in epoch 1, 0 in epoch 2.
  - done=1, converged=1, epoch_count=2, weights=(1,1), bias=-1.
- XOR samples (1,1,-1) (1,-1,+1) (-1,1,+1) (-1,-1,-1) with MAX_EPOCHS=5: done=1, converged=0, epoch_count=5.
- Saturation (WEIGHT_W=4, DATA_W=7, N_INPUTS=1), sample (7,+1) with theta=100 repeated:
  - w0 climbs 0, 7 and then clamps at 7.
  - bias increments by 1 per update and clamps at 7.
  - No wrap to negative.
- Backpressure: hold s_valid=0 for 10 cycles in FETCH -> s_ready stays 1, no counters change. Random valid gaps produce results identical to the AND case.
- start with num_samples=0 -> done=1, converged=1, epoch_count=0 on the next cycle. start pulsed mid-epoch is ignored.
- rst_n low in the MAC state of epoch 1 -> all outputs 0 asynchronously. A fresh start then reproduces the AND result exactly.
